// File: rtl/alu_seq_ctrl_if.sv
// Bundle of the request, ALU and retire signals of alu_seq_ctrl.
// slave  : controller view (takes requests, drives ALU operands and retire outputs).
// master : mirror view for the decode/operand-fetch, ALU and register-file side.
//   req_valid/req_ready  op handshake; req_cond/opc/s/rd/a/b/shc op fields
//   alu_a/alu_b/alu_sel  ALU operands and select; alu_res 64-bit ALU result (bit 32 = carry)
//   flags_load/flags_in  MSR-style NZCV write
//   wr_en/wr_addr/wr_data register-file write; done retire pulse; flags NZCV register
interface alu_seq_ctrl_if #(
    parameter int DW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_cond;
    logic [3:0]    req_opc;
    logic          req_s;
    logic [3:0]    req_rd;
    logic [DW-1:0] req_a;
    logic [DW-1:0] req_b;
    logic          req_shc;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [3:0]    alu_sel;
    logic [2*DW-1:0] alu_res;
    logic          flags_load;
    logic [3:0]    flags_in;
    logic          wr_en;
    logic [3:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          done;
    logic [3:0]    flags;

    modport slave (
        input  req_valid, req_cond, req_opc, req_s, req_rd, req_a, req_b, req_shc,
        input  alu_res, flags_load, flags_in,
        output req_ready, alu_a, alu_b, alu_sel, wr_en, wr_addr, wr_data, done, flags
    );

    modport master (
        output req_valid, req_cond, req_opc, req_s, req_rd, req_a, req_b, req_shc,
        output alu_res, flags_load, flags_in,
        input  req_ready, alu_a, alu_b, alu_sel, wr_en, wr_addr, wr_data, done, flags
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for the 32-bit data-processing ALU.
// Accepts one op at a time, evaluates the ARM condition against the NZCV register it owns,
// drives the ALU for one or two passes (ADC/SBC/RSC need a second +/-1 pass because the ALU
// has no carry-in), then retires with a single-cycle register write and a flag update.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  alu_seq_ctrl_if.slave (request handshake, ALU operands/result, retire, flags)
module alu_seq_ctrl #(
    parameter int DW = 32
) (
    input logic          clk,
    input logic          rst,
    alu_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StPass1, StPass2, StRetire} state_e;

    localparam logic [3:0] OpSub = 4'b0010;
    localparam logic [3:0] OpRsb = 4'b0011;
    localparam logic [3:0] OpAdd = 4'b0100;
    localparam logic [3:0] OpAdc = 4'b0101;
    localparam logic [3:0] OpSbc = 4'b0110;
    localparam logic [3:0] OpRsc = 4'b0111;
    localparam logic [3:0] OpCmp = 4'b1010;
    localparam logic [3:0] OpCmn = 4'b1011;

    state_e        state_q, state_d;
    logic [3:0]    cond_q, cond_d;
    logic [3:0]    opc_q, opc_d;
    logic          s_q, s_d;
    logic [3:0]    rd_q, rd_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic          shc_q, shc_d;
    logic [DW-1:0] res_q, res_d;
    logic          b1_q, b1_d;
    logic          b2_q, b2_d;
    logic          squash_q, squash_d;
    logic [3:0]    flags_q, flags_d;

    logic          is_test;
    logic [3:0]    new_flags;
    logic          unused_res;

    assign unused_res = ^bus.alu_res[2*DW-1:DW+1];
    // TST/TEQ/CMP/CMN only set flags, never write the register file.
    assign is_test    = (opc_q[3:2] == 2'b10);
    assign bus.flags  = flags_q;

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (c)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = cf;
            4'b0011: cond_pass = !cf;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = cf && !z;
            4'b1001: cond_pass = !cf || z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z && (n == v);
            4'b1101: cond_pass = z || (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    // NZCV from the final result; C/V depend on the op family.
    always_comb begin
        new_flags[3] = res_q[DW-1];
        new_flags[2] = (res_q == '0);
        new_flags[1] = shc_q;
        new_flags[0] = flags_q[0];
        case (opc_q)
            OpAdd, OpAdc, OpCmn: begin
                new_flags[1] = b1_q | b2_q;
                new_flags[0] = (a_q[DW-1] == b_q[DW-1]) && (res_q[DW-1] != a_q[DW-1]);
            end
            OpSub, OpSbc, OpCmp: begin
                new_flags[1] = ~b1_q & ~b2_q;
                new_flags[0] = (a_q[DW-1] != b_q[DW-1]) && (res_q[DW-1] != a_q[DW-1]);
            end
            OpRsb, OpRsc: begin
                new_flags[1] = ~b1_q & ~b2_q;
                new_flags[0] = (b_q[DW-1] != a_q[DW-1]) && (res_q[DW-1] != b_q[DW-1]);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cond_d        = cond_q;
        opc_d         = opc_q;
        s_d           = s_q;
        rd_d          = rd_q;
        a_d           = a_q;
        b_d           = b_q;
        shc_d         = shc_q;
        res_d         = res_q;
        b1_d          = b1_q;
        b2_d          = b2_q;
        squash_d      = squash_q;
        flags_d       = flags_q;
        bus.req_ready = 1'b0;
        bus.alu_a     = '0;
        bus.alu_b     = '0;
        bus.alu_sel   = 4'b0000;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = 4'b0000;
        bus.wr_data   = '0;
        bus.done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                bus.req_ready = 1'b1;
                if (bus.flags_load) begin
                    flags_d = bus.flags_in;
                end
                if (bus.req_valid) begin
                    cond_d   = bus.req_cond;
                    opc_d    = bus.req_opc;
                    s_d      = bus.req_s;
                    rd_d     = bus.req_rd;
                    a_d      = bus.req_a;
                    b_d      = bus.req_b;
                    shc_d    = bus.req_shc;
                    squash_d = 1'b0;
                    b1_d     = 1'b0;
                    b2_d     = 1'b0;
                    state_d  = StPass1;
                end
            end
            StPass1: begin
                if (!cond_pass(cond_q, flags_q)) begin
                    squash_d = 1'b1;
                    state_d  = StRetire;
                end else begin
                    bus.alu_a = a_q;
                    bus.alu_b = b_q;
                    case (opc_q)
                        OpAdc:   bus.alu_sel = OpAdd;
                        OpSbc:   bus.alu_sel = OpSub;
                        OpRsc:   bus.alu_sel = OpRsb;
                        default: bus.alu_sel = opc_q;
                    endcase
                    res_d = bus.alu_res[DW-1:0];
                    b1_d  = bus.alu_res[DW];
                    b2_d  = 1'b0;
                    // Second pass folds in the carry: +1 for ADC with C, -1 for SBC/RSC without C.
                    if ((opc_q == OpAdc && flags_q[1]) ||
                        ((opc_q == OpSbc || opc_q == OpRsc) && !flags_q[1])) begin
                        state_d = StPass2;
                    end else begin
                        state_d = StRetire;
                    end
                end
            end
            StPass2: begin
                bus.alu_a   = res_q;
                bus.alu_b   = DW'(1);
                bus.alu_sel = (opc_q == OpAdc) ? OpAdd : OpSub;
                res_d       = bus.alu_res[DW-1:0];
                b2_d        = bus.alu_res[DW];
                state_d     = StRetire;
            end
            StRetire: begin
                bus.done = 1'b1;
                if (!squash_q) begin
                    if (!is_test) begin
                        bus.wr_en   = 1'b1;
                        bus.wr_addr = rd_q;
                        bus.wr_data = res_q;
                    end
                    if (s_q || is_test) begin
                        flags_d = new_flags;
                    end
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cond_q   <= 4'b0000;
            opc_q    <= 4'b0000;
            s_q      <= 1'b0;
            rd_q     <= 4'b0000;
            a_q      <= '0;
            b_q      <= '0;
            shc_q    <= 1'b0;
            res_q    <= '0;
            b1_q     <= 1'b0;
            b2_q     <= 1'b0;
            squash_q <= 1'b0;
            flags_q  <= 4'b0000;
        end else begin
            state_q  <= state_d;
            cond_q   <= cond_d;
            opc_q    <= opc_d;
            s_q      <= s_d;
            rd_q     <= rd_d;
            a_q      <= a_d;
            b_q      <= b_d;
            shc_q    <= shc_d;
            res_q    <= res_d;
            b1_q     <= b1_d;
            b2_q     <= b2_d;
            squash_q <= squash_d;
            flags_q  <= flags_d;
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl with a behavioural model of the external ALU.
module tb_alu_seq_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_seq_ctrl_if #(.DW(32)) bus ();

    alu_seq_ctrl #(.DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // External ALU: 64-bit result, bit 32 = carry (add) or borrow (subtract).
    logic [63:0] a64, b64;
    always_comb begin
        a64 = {32'b0, bus.alu_a};
        b64 = {32'b0, bus.alu_b};
        case (bus.alu_sel)
            4'b0000, 4'b1000: bus.alu_res = a64 & b64;
            4'b0001, 4'b1001: bus.alu_res = a64 ^ b64;
            4'b0010, 4'b1010: bus.alu_res = a64 - b64;
            4'b0011:          bus.alu_res = b64 - a64;
            4'b0100, 4'b1011: bus.alu_res = a64 + b64;
            4'b1100:          bus.alu_res = a64 | b64;
            4'b1101:          bus.alu_res = b64;
            4'b1110:          bus.alu_res = a64 & ~b64;
            4'b1111:          bus.alu_res = {32'b0, ~bus.alu_b};
            default:          bus.alu_res = 64'b0;
        endcase
    end

    // Offers one op starting at a negedge and follows it to done. lat counts cycles from the
    // accept cycle (0) to the done cycle; 0 means done never came within the budget.
    task automatic run_op(input logic ld, input logic [3:0] ldv, input logic [3:0] cond,
                          input logic [3:0] opc, input logic s, input logic [3:0] rd,
                          input logic [31:0] a, input logic [31:0] b, input logic shc,
                          output int lat, output int wr_cnt, output logic [3:0] waddr,
                          output logic [31:0] wdata, output logic rdy_done,
                          output logic [3:0] sel1, output logic [3:0] sel2);
        bus.req_valid  = 1'b1;
        bus.req_cond   = cond;
        bus.req_opc    = opc;
        bus.req_s      = s;
        bus.req_rd     = rd;
        bus.req_a      = a;
        bus.req_b      = b;
        bus.req_shc    = shc;
        bus.flags_load = ld;
        bus.flags_in   = ldv;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.flags_load = 1'b0;
        lat = 0; wr_cnt = 0; waddr = 4'h0; wdata = 32'h0; rdy_done = 1'b1;
        sel1 = 4'h0; sel2 = 4'h0;
        for (int cyc = 1; cyc <= 8 && lat == 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) sel1 = bus.alu_sel;
            if (cyc == 2) sel2 = bus.alu_sel;
            if (bus.wr_en) begin
                wr_cnt++;
                waddr = bus.wr_addr;
                wdata = bus.wr_data;
            end
            if (bus.done) begin
                lat      = cyc;
                rdy_done = bus.req_ready;
            end
        end
        @(negedge clk);
    endtask

    int          lat, wr_cnt;
    logic [3:0]  waddr, sel1, sel2;
    logic [31:0] wdata;
    logic        rdy_done;

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
        n_cmp++; if (bus.flags !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", bus.flags); end
        n_cmp++; if ({bus.done, bus.wr_en, bus.alu_sel, bus.alu_a} !== 38'h0) begin
            n_bad++; $display("FAIL reset_outs: done=%b wr_en=%b sel=%h a=%h want all 0", bus.done, bus.wr_en, bus.alu_sel, bus.alu_a);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add_overflow();
        run_op(1'b0, 4'h0, 4'hE, 4'b0100, 1'b1, 4'd3, 32'h7FFF_FFFF, 32'h1, 1'b0,
               lat, wr_cnt, waddr, wdata, rdy_done, sel1, sel2);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL add_lat: got %0d want 2", lat); end
        n_cmp++; if (wr_cnt !== 1 || waddr !== 4'd3 || wdata !== 32'h8000_0000) begin
            n_bad++; $display("FAIL add_wr: cnt=%0d addr=%0d data=%h want 1/3/80000000", wr_cnt, waddr, wdata);
        end
        n_cmp++; if (sel1 !== 4'b0100) begin n_bad++; $display("FAIL add_sel: got %b want 0100", sel1); end
        n_cmp++; if (bus.flags !== 4'b1001) begin n_bad++; $display("FAIL add_flags: got %b want 1001", bus.flags); end
    endtask

    task automatic test_cmp();
        run_op(1'b0, 4'h0, 4'hE, 4'b1010, 1'b0, 4'd1, 32'd5, 32'd5, 1'b0,
               lat, wr_cnt, waddr, wdata, rdy_done, sel1, sel2);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL cmp_lat: got %0d want 2", lat); end
        n_cmp++; if (wr_cnt !== 0) begin n_bad++; $display("FAIL cmp_nowr: got %0d writes want 0", wr_cnt); end
        n_cmp++; if (bus.flags !== 4'b0110) begin n_bad++; $display("FAIL cmp_flags: got %b want 0110", bus.flags); end
    endtask

    task automatic test_flags_load_adc();
        run_op(1'b1, 4'b0010, 4'hE, 4'b0101, 1'b1, 4'd7, 32'hFFFF_FFFF, 32'h0, 1'b0,
               lat, wr_cnt, waddr, wdata, rdy_done, sel1, sel2);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL adc_lat: got %0d want 3", lat); end
        n_cmp++; if (sel1 !== 4'b0100 || sel2 !== 4'b0100) begin
            n_bad++; $display("FAIL adc_sel: got %b/%b want 0100/0100", sel1, sel2);
        end
        n_cmp++; if (wr_cnt !== 1 || waddr !== 4'd7 || wdata !== 32'h0) begin
            n_bad++; $display("FAIL adc_wr: cnt=%0d addr=%0d data=%h want 1/7/0", wr_cnt, waddr, wdata);
        end
        n_cmp++; if (bus.flags !== 4'b0110) begin n_bad++; $display("FAIL adc_flags: got %b want 0110", bus.flags); end
    endtask

    task automatic test_sbc();
        run_op(1'b1, 4'b0000, 4'hE, 4'b0110, 1'b1, 4'd2, 32'd10, 32'd3, 1'b0,
               lat, wr_cnt, waddr, wdata, rdy_done, sel1, sel2);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL sbc_lat: got %0d want 3", lat); end
        n_cmp++; if (sel1 !== 4'b0010 || sel2 !== 4'b0010) begin
            n_bad++; $display("FAIL sbc_sel: got %b/%b want 0010/0010", sel1, sel2);
        end
        n_cmp++; if (wr_cnt !== 1 || wdata !== 32'd6) begin
            n_bad++; $display("FAIL sbc_wr: cnt=%0d data=%h want 1/6", wr_cnt, wdata);
        end
        n_cmp++; if (bus.flags !== 4'b0010) begin n_bad++; $display("FAIL sbc_flags: got %b want 0010", bus.flags); end
    endtask

    task automatic test_rsc();
        run_op(1'b1, 4'b0000, 4'hE, 4'b0111, 1'b1, 4'd4, 32'd3, 32'd10, 1'b0,
               lat, wr_cnt, waddr, wdata, rdy_done, sel1, sel2);
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rsc_lat: got %0d want 3", lat); end
        n_cmp++; if (sel1 !== 4'b0011 || sel2 !== 4'b0010) begin
            n_bad++; $display("FAIL rsc_sel: got %b/%b want 0011/0010", sel1, sel2);
        end
        n_cmp++; if (wr_cnt !== 1 || wdata !== 32'd6) begin
            n_bad++; $display("FAIL rsc_wr: cnt=%0d data=%h want 1/6", wr_cnt, wdata);
        end
        n_cmp++; if (bus.flags !== 4'b0010) begin n_bad++; $display("FAIL rsc_flags: got %b want 0010", bus.flags); end
    endtask

    task automatic test_cond_fail();
        run_op(1'b1, 4'b0000, 4'h0, 4'b1101, 1'b1, 4'd5, 32'h0, 32'h1234, 1'b1,
               lat, wr_cnt, waddr, wdata, rdy_done, sel1, sel2);
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL eq_lat: got %0d want 2", lat); end
        n_cmp++; if (wr_cnt !== 0 || sel1 !== 4'h0) begin
            n_bad++; $display("FAIL eq_squash: writes=%0d sel=%b want 0/0000", wr_cnt, sel1);
        end
        n_cmp++; if (bus.flags !== 4'b0000) begin n_bad++; $display("FAIL eq_flags: got %b want 0000", bus.flags); end
    endtask

    task automatic test_logical();
        // MOV #0 with S=1: C from the shifter, V preserved from the loaded 0001.
        run_op(1'b1, 4'b0001, 4'hE, 4'b1101, 1'b1, 4'd9, 32'hDEAD_BEEF, 32'h0, 1'b1,
               lat, wr_cnt, waddr, wdata, rdy_done, sel1, sel2);
        n_cmp++; if (wr_cnt !== 1 || waddr !== 4'd9 || wdata !== 32'h0) begin
            n_bad++; $display("FAIL mov_wr: cnt=%0d addr=%0d data=%h want 1/9/0", wr_cnt, waddr, wdata);
        end
        n_cmp++; if (bus.flags !== 4'b0111) begin n_bad++; $display("FAIL mov_flags: got %b want 0111", bus.flags); end
    endtask

    task automatic test_cond_ge_nv();
        run_op(1'b1, 4'b1001, 4'hA, 4'b0100, 1'b0, 4'd6, 32'd1, 32'd2, 1'b0,
               lat, wr_cnt, waddr, wdata, rdy_done, sel1, sel2);
        n_cmp++; if (wr_cnt !== 1 || wdata !== 32'd3) begin
            n_bad++; $display("FAIL ge_wr: cnt=%0d data=%h want 1/3", wr_cnt, wdata);
        end
        n_cmp++; if (bus.flags !== 4'b1001) begin n_bad++; $display("FAIL ge_flags: got %b want 1001", bus.flags); end
        run_op(1'b0, 4'h0, 4'hF, 4'b1010, 1'b1, 4'd6, 32'd1, 32'd2, 1'b0,
               lat, wr_cnt, waddr, wdata, rdy_done, sel1, sel2);
        n_cmp++; if (lat !== 2 || wr_cnt !== 0) begin
            n_bad++; $display("FAIL nv_squash: lat=%0d writes=%0d want 2/0", lat, wr_cnt);
        end
        n_cmp++; if (bus.flags !== 4'b1001) begin n_bad++; $display("FAIL nv_flags: got %b want 1001", bus.flags); end
    endtask

    task automatic test_back_to_back();
        run_op(1'b0, 4'h0, 4'hE, 4'b0001, 1'b0, 4'd8, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0,
               lat, wr_cnt, waddr, wdata, rdy_done, sel1, sel2);
        n_cmp++; if (rdy_done !== 1'b0) begin n_bad++; $display("FAIL b2b_busy: ready=%b in retire want 0", rdy_done); end
        n_cmp++; if (bus.req_ready !== 1'b1 || bus.done !== 1'b0) begin
            n_bad++; $display("FAIL b2b_idle: ready=%b done=%b want 1/0", bus.req_ready, bus.done);
        end
        n_cmp++; if (wdata !== 32'h0FF0_0FF0) begin n_bad++; $display("FAIL b2b_eor: got %h want 0ff00ff0", wdata); end
        run_op(1'b0, 4'h0, 4'hE, 4'b1110, 1'b0, 4'd8, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b0,
               lat, wr_cnt, waddr, wdata, rdy_done, sel1, sel2);
        n_cmp++; if (lat !== 2 || wdata !== 32'hFFFF_0000) begin
            n_bad++; $display("FAIL b2b_bic: lat=%0d data=%h want 2/ffff0000", lat, wdata);
        end
    endtask

    task automatic test_reset_in_pass2();
        int seen;
        seen = 0;
        bus.req_valid  = 1'b1;
        bus.req_cond   = 4'hE;
        bus.req_opc    = 4'b0101;
        bus.req_s      = 1'b1;
        bus.req_rd     = 4'd1;
        bus.req_a      = 32'hFFFF_FFFF;
        bus.req_b      = 32'h0;
        bus.flags_load = 1'b1;
        bus.flags_in   = 4'b0010;
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.flags_load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (bus.alu_a !== 32'hFFFF_FFFF || bus.alu_b !== 32'h1 || bus.alu_sel !== 4'b0100) begin
            n_bad++; $display("FAIL p2_drive: a=%h b=%h sel=%b want ffffffff/1/0100", bus.alu_a, bus.alu_b, bus.alu_sel);
        end
        rst = 1'b1;
        @(negedge clk);
        if (bus.wr_en || bus.done) seen++;
        n_cmp++; if (bus.req_ready !== 1'b1 || bus.flags !== 4'b0000) begin
            n_bad++; $display("FAIL p2_reset: ready=%b flags=%b want 1/0000", bus.req_ready, bus.flags);
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.wr_en || bus.done) seen++;
        end
        n_cmp++; if (seen !== 0 || bus.req_ready !== 1'b1 || bus.flags !== 4'b0000) begin
            n_bad++; $display("FAIL p2_drop: retire_cycles=%0d ready=%b flags=%b want 0/1/0000", seen, bus.req_ready, bus.flags);
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_cond   = 4'h0;
        bus.req_opc    = 4'h0;
        bus.req_s      = 1'b0;
        bus.req_rd     = 4'h0;
        bus.req_a      = 32'h0;
        bus.req_b      = 32'h0;
        bus.req_shc    = 1'b0;
        bus.flags_load = 1'b0;
        bus.flags_in   = 4'h0;
        @(negedge clk);
        test_reset();
        test_add_overflow();
        test_cmp();
        test_flags_load_adc();
        test_sbc();
        test_rsc();
        test_cond_fail();
        test_logical();
        test_cond_ge_nv();
        test_back_to_back();
        test_reset_in_pass2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
